// File: rtl/sargantana_icache_pkg.sv
// Shared types for the icache L2 request path: NC FSM states and transaction tags.
package sargantana_icache_pkg;

    typedef enum logic [1:0] {
        NC_IDLE = 2'd0,
        NC_PEND = 2'd1,
        NC_WAIT = 2'd2
    } nc_state_e;

    // The request/response nc bit doubles as the transaction tag.
    localparam logic NC_TAG = 1'b1;
    localparam logic IC_TAG = 1'b0;

    localparam int unsigned PADDR_W = 40;

endpackage

// File: rtl/nc_timeout_cnt.sv
// Wait-cycle counter for the NC path; expired_o is high on the TIMEOUT_CYCLES-th
// consecutive cycle of run_i and stays high until run_i drops.
module nc_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturate at the limit so a deferred expiry is still visible next cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == LIMIT);

endmodule

// File: rtl/nc_l2_req_adapter.sv
// Merges single-pulse NC fetches and held icache misses onto one L2 request port.
// Optional NC wait timeout with stale-response dropping: define NC_L2_TIMEOUT_EN.
module nc_l2_req_adapter
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned L2_DATA_WIDTH  = 512,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     nc_req_valid_i,
    input  logic [PADDR_W-1:0]       nc_req_addr_i,
    input  logic                     icache_miss_valid_i,
    input  logic [PADDR_W-1:0]       icache_miss_addr_i,
    output logic                     icache_miss_ready_o,
    output logic                     l2_req_valid_o,
    input  logic                     l2_req_ready_i,
    output logic [PADDR_W-1:0]       l2_req_addr_o,
    output logic                     l2_req_nc_o,
    input  logic                     l2_rsp_valid_i,
    input  logic                     l2_rsp_nc_i,
    input  logic [L2_DATA_WIDTH-1:0] l2_rsp_data_i,
    output logic                     nc_grant_valid_o,
    output logic                     icache_rsp_valid_o,
    output logic [L2_DATA_WIDTH-1:0] rsp_data_o,
    output logic                     nc_err_o,
    output logic [1:0]               nc_state_o
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    nc_state_e          state_q, state_d;
    logic [PADDR_W-1:0] addr_q, addr_d;

    logic in_wait;
    logic nc_rsp;
    logic nc_issue;
    logic miss_fwd;
    logic nc_rsp_grant;
    logic timeout_fire;
    logic stale;

    assign in_wait = (state_q == NC_WAIT);
    assign nc_rsp  = l2_rsp_valid_i && (l2_rsp_nc_i == NC_TAG);

`ifdef NC_L2_TIMEOUT_EN
    logic stale_q, stale_d;
    logic cnt_expired;

    nc_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .run_i    (in_wait),
        .expired_o(cnt_expired)
    );

    // Expiry yields to any response that cycle: rsp_data_o is shared with the icache grant.
    assign timeout_fire = cnt_expired && !l2_rsp_valid_i;
    assign stale        = stale_q;

    always_comb begin
        stale_d = stale_q;
        if (timeout_fire) begin
            stale_d = 1'b1;
        end else if (nc_rsp) begin
            stale_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stale_q <= 1'b0;
        end else begin
            stale_q <= stale_d;
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign stale        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            NC_IDLE: begin
                if (nc_req_valid_i) begin
                    state_d = NC_PEND;
                    addr_d  = nc_req_addr_i;
                end
            end
            NC_PEND: begin
                if (nc_issue && l2_req_ready_i) begin
                    state_d = NC_WAIT;
                end
            end
            NC_WAIT: begin
                if (nc_rsp || timeout_fire) begin
                    state_d = NC_IDLE;
                end
            end
            default: begin
                state_d = NC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= NC_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Handshake: a request transfers in any cycle where l2_req_valid_o && l2_req_ready_i;
    // the miss source holds icache_miss_valid_i until icache_miss_ready_o, while an NC
    // pulse is held internally in NC_PEND. Responses are single-cycle with no back-pressure.
    assign nc_issue = (state_q == NC_PEND) && !stale;
    assign miss_fwd = (state_q != NC_PEND) && icache_miss_valid_i;

    assign l2_req_valid_o      = nc_issue || miss_fwd;
    assign l2_req_nc_o         = nc_issue ? NC_TAG : IC_TAG;
    assign l2_req_addr_o       = nc_issue ? addr_q : (miss_fwd ? icache_miss_addr_i : '0);
    assign icache_miss_ready_o = miss_fwd && l2_req_ready_i;

    assign nc_rsp_grant       = nc_rsp && in_wait;
    assign nc_grant_valid_o   = nc_rsp_grant || timeout_fire;
    assign icache_rsp_valid_o = l2_rsp_valid_i && (l2_rsp_nc_i == IC_TAG);
    assign nc_err_o           = timeout_fire;
    // Data is zero unless a real grant is carrying it, which also zeroes timeout completions.
    assign rsp_data_o         = (nc_rsp_grant || icache_rsp_valid_o) ? l2_rsp_data_i : '0;
    assign nc_state_o         = state_q;

endmodule

// File: tb/tb_nc_l2_req_adapter.sv
// Directed bench for nc_l2_req_adapter; exercises the timeout path when NC_L2_TIMEOUT_EN is defined.
module tb_nc_l2_req_adapter;

    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic          nc_req_valid_i;
    logic [39:0]   nc_req_addr_i;
    logic          icache_miss_valid_i;
    logic [39:0]   icache_miss_addr_i;
    logic          icache_miss_ready_o;
    logic          l2_req_valid_o;
    logic          l2_req_ready_i;
    logic [39:0]   l2_req_addr_o;
    logic          l2_req_nc_o;
    logic          l2_rsp_valid_i;
    logic          l2_rsp_nc_i;
    logic [DW-1:0] l2_rsp_data_i;
    logic          nc_grant_valid_o;
    logic          icache_rsp_valid_o;
    logic [DW-1:0] rsp_data_o;
    logic          nc_err_o;
    logic [1:0]    nc_state_o;

    int total = 0;
    int bad   = 0;

    nc_l2_req_adapter #(
        .L2_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i              (clk),
        .rstn_i             (rstn_i),
        .nc_req_valid_i     (nc_req_valid_i),
        .nc_req_addr_i      (nc_req_addr_i),
        .icache_miss_valid_i(icache_miss_valid_i),
        .icache_miss_addr_i (icache_miss_addr_i),
        .icache_miss_ready_o(icache_miss_ready_o),
        .l2_req_valid_o     (l2_req_valid_o),
        .l2_req_ready_i     (l2_req_ready_i),
        .l2_req_addr_o      (l2_req_addr_o),
        .l2_req_nc_o        (l2_req_nc_o),
        .l2_rsp_valid_i     (l2_rsp_valid_i),
        .l2_rsp_nc_i        (l2_rsp_nc_i),
        .l2_rsp_data_i      (l2_rsp_data_i),
        .nc_grant_valid_o   (nc_grant_valid_o),
        .icache_rsp_valid_o (icache_rsp_valid_o),
        .rsp_data_o         (rsp_data_o),
        .nc_err_o           (nc_err_o),
        .nc_state_o         (nc_state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        nc_req_valid_i      = 1'b0;
        nc_req_addr_i       = '0;
        icache_miss_valid_i = 1'b0;
        icache_miss_addr_i  = '0;
        l2_req_ready_i      = 1'b0;
        l2_rsp_valid_i      = 1'b0;
        l2_rsp_nc_i         = 1'b0;
        l2_rsp_data_i       = '0;
    endtask

    // Leaves the DUT in NC_WAIT with all inputs idle, one tick after the request was accepted.
    task automatic go_to_wait(input logic [39:0] addr);
        tick();
        clear_inputs();
        nc_req_valid_i = 1'b1;
        nc_req_addr_i  = addr;
        tick();
        clear_inputs();
        l2_req_ready_i = 1'b1;
        tick();
        clear_inputs();
        settle();
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        clear_inputs();
        repeat (3) tick();
        total++; if (l2_req_valid_o !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%0b exp=0", l2_req_valid_o); end
        total++; if (nc_grant_valid_o !== 1'b0 || nc_err_o !== 1'b0) begin bad++; $display("FAIL rst_grant got=%0b/%0b exp=0/0", nc_grant_valid_o, nc_err_o); end
        total++; if (rsp_data_o !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", rsp_data_o); end
        rstn_i = 1'b1;
        tick();
        total++; if (nc_state_o !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", nc_state_o); end
        total++; if (l2_req_addr_o !== 40'h0 || l2_req_nc_o !== 1'b0 || icache_miss_ready_o !== 1'b0 || icache_rsp_valid_o !== 1'b0) begin
            bad++; $display("FAIL rst_outs got addr=%h nc=%0b mr=%0b ir=%0b exp=0", l2_req_addr_o, l2_req_nc_o, icache_miss_ready_o, icache_rsp_valid_o);
        end
    endtask

    task automatic test_nc_basic();
        tick();
        clear_inputs();
        nc_req_valid_i = 1'b1;
        nc_req_addr_i  = 40'h00_0001_0008;
        settle();
        total++; if (l2_req_valid_o !== 1'b0) begin bad++; $display("FAIL basic_no_early_req got=%0b exp=0", l2_req_valid_o); end
        tick();
        clear_inputs();
        l2_req_ready_i = 1'b1;
        settle();
        total++; if (l2_req_valid_o !== 1'b1 || l2_req_nc_o !== 1'b1) begin bad++; $display("FAIL basic_req got=%0b nc=%0b exp=1/1", l2_req_valid_o, l2_req_nc_o); end
        total++; if (l2_req_addr_o !== 40'h00_0001_0008) begin bad++; $display("FAIL basic_addr got=%h exp=0000010008", l2_req_addr_o); end
        tick();
        clear_inputs();
        l2_rsp_valid_i = 1'b1;
        l2_rsp_nc_i    = 1'b1;
        l2_rsp_data_i  = 512'hDEAD;
        settle();
        total++; if (nc_grant_valid_o !== 1'b1 || icache_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL basic_grant got=%0b ic=%0b exp=1/0", nc_grant_valid_o, icache_rsp_valid_o); end
        total++; if (rsp_data_o !== 512'hDEAD) begin bad++; $display("FAIL basic_data got=%h exp=dead", rsp_data_o); end
        total++; if (nc_err_o !== 1'b0) begin bad++; $display("FAIL basic_err got=%0b exp=0", nc_err_o); end
        tick();
        clear_inputs();
        settle();
        total++; if (nc_state_o !== 2'd0) begin bad++; $display("FAIL basic_back_idle got=%0d exp=0", nc_state_o); end
    endtask

    task automatic test_arbitration();
        tick();
        clear_inputs();
        nc_req_valid_i = 1'b1;
        nc_req_addr_i  = 40'h00_0002_0010;
        tick();
        clear_inputs();
        icache_miss_valid_i = 1'b1;
        icache_miss_addr_i  = 40'h00_8000_0040;
        l2_req_ready_i      = 1'b1;
        settle();
        total++; if (l2_req_nc_o !== 1'b1 || l2_req_addr_o !== 40'h00_0002_0010) begin bad++; $display("FAIL arb_nc_first got nc=%0b addr=%h exp=1/0000020010", l2_req_nc_o, l2_req_addr_o); end
        total++; if (icache_miss_ready_o !== 1'b0) begin bad++; $display("FAIL arb_miss_blocked got=%0b exp=0", icache_miss_ready_o); end
        tick();
        settle();
        total++; if (l2_req_valid_o !== 1'b1 || l2_req_nc_o !== 1'b0 || l2_req_addr_o !== 40'h00_8000_0040) begin
            bad++; $display("FAIL arb_miss_fwd got v=%0b nc=%0b addr=%h exp=1/0/0080000040", l2_req_valid_o, l2_req_nc_o, l2_req_addr_o);
        end
        total++; if (icache_miss_ready_o !== 1'b1) begin bad++; $display("FAIL arb_miss_ready got=%0b exp=1", icache_miss_ready_o); end
        tick();
        clear_inputs();
        l2_rsp_valid_i = 1'b1;
        l2_rsp_nc_i    = 1'b1;
        l2_rsp_data_i  = 512'hBEEF;
        settle();
        total++; if (nc_grant_valid_o !== 1'b1 || rsp_data_o !== 512'hBEEF) begin bad++; $display("FAIL arb_grant got=%0b data=%h exp=1/beef", nc_grant_valid_o, rsp_data_o); end
        tick();
        clear_inputs();
    endtask

    task automatic test_ignore_second();
        tick();
        clear_inputs();
        nc_req_valid_i = 1'b1;
        nc_req_addr_i  = 40'h00_0000_1000;
        tick();
        clear_inputs();
        tick();
        nc_req_valid_i = 1'b1;
        nc_req_addr_i  = 40'h00_0000_2000;
        tick();
        clear_inputs();
        settle();
        total++; if (nc_state_o !== 2'd1) begin bad++; $display("FAIL ign_still_pend got=%0d exp=1", nc_state_o); end
        total++; if (l2_req_addr_o !== 40'h00_0000_1000) begin bad++; $display("FAIL ign_addr got=%h exp=0000001000", l2_req_addr_o); end
        l2_req_ready_i = 1'b1;
        tick();
        clear_inputs();
        l2_rsp_valid_i = 1'b1;
        l2_rsp_nc_i    = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_miss_rsp_in_wait();
        go_to_wait(40'h00_0000_3008);
        l2_rsp_valid_i = 1'b1;
        l2_rsp_nc_i    = 1'b0;
        l2_rsp_data_i  = 512'h1234;
        settle();
        total++; if (icache_rsp_valid_o !== 1'b1 || nc_grant_valid_o !== 1'b0) begin bad++; $display("FAIL mrsp_route got ic=%0b nc=%0b exp=1/0", icache_rsp_valid_o, nc_grant_valid_o); end
        total++; if (rsp_data_o !== 512'h1234) begin bad++; $display("FAIL mrsp_data got=%h exp=1234", rsp_data_o); end
        tick();
        clear_inputs();
        settle();
        total++; if (nc_state_o !== 2'd2) begin bad++; $display("FAIL mrsp_state got=%0d exp=2", nc_state_o); end
        l2_rsp_valid_i = 1'b1;
        l2_rsp_nc_i    = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_drop_and_overlap();
        tick();
        clear_inputs();
        l2_rsp_valid_i = 1'b1;
        l2_rsp_nc_i    = 1'b1;
        l2_rsp_data_i  = 512'h55;
        nc_req_valid_i = 1'b1;
        nc_req_addr_i  = 40'h00_0000_4000;
        settle();
        total++; if (nc_grant_valid_o !== 1'b0 || icache_rsp_valid_o !== 1'b0 || rsp_data_o !== '0) begin
            bad++; $display("FAIL drop_idle got nc=%0b ic=%0b data=%h exp=0/0/0", nc_grant_valid_o, icache_rsp_valid_o, rsp_data_o);
        end
        tick();
        clear_inputs();
        settle();
        total++; if (nc_state_o !== 2'd1 || l2_req_addr_o !== 40'h00_0000_4000) begin bad++; $display("FAIL overlap_latch got st=%0d addr=%h exp=1/0000004000", nc_state_o, l2_req_addr_o); end
        l2_req_ready_i = 1'b1;
        tick();
        clear_inputs();
        l2_rsp_valid_i = 1'b1;
        l2_rsp_nc_i    = 1'b1;
        l2_rsp_data_i  = 512'h66;
        nc_req_valid_i = 1'b1;
        nc_req_addr_i  = 40'h00_0000_5000;
        settle();
        total++; if (nc_grant_valid_o !== 1'b1) begin bad++; $display("FAIL wait_done_grant got=%0b exp=1", nc_grant_valid_o); end
        tick();
        clear_inputs();
        settle();
        total++; if (nc_state_o !== 2'd0 || l2_req_valid_o !== 1'b0) begin bad++; $display("FAIL pulse_at_done_ignored got st=%0d v=%0b exp=0/0", nc_state_o, l2_req_valid_o); end
    endtask

    task automatic test_reset_mid();
        go_to_wait(40'h00_0000_6000);
        rstn_i = 1'b0;
        settle();
        total++; if (nc_state_o !== 2'd0) begin bad++; $display("FAIL rmid_state got=%0d exp=0", nc_state_o); end
        l2_rsp_valid_i = 1'b1;
        l2_rsp_nc_i    = 1'b1;
        l2_rsp_data_i  = 512'hAA;
        settle();
        total++; if (nc_grant_valid_o !== 1'b0 || rsp_data_o !== '0 || l2_req_valid_o !== 1'b0 || nc_err_o !== 1'b0) begin
            bad++; $display("FAIL rmid_in_reset got g=%0b d=%h v=%0b e=%0b exp=0", nc_grant_valid_o, rsp_data_o, l2_req_valid_o, nc_err_o);
        end
        tick();
        rstn_i = 1'b1;
        settle();
        total++; if (nc_grant_valid_o !== 1'b0 || icache_rsp_valid_o !== 1'b0 || rsp_data_o !== '0 || icache_miss_ready_o !== 1'b0) begin
            bad++; $display("FAIL rmid_late_rsp got g=%0b ic=%0b d=%h mr=%0b exp=0", nc_grant_valid_o, icache_rsp_valid_o, rsp_data_o, icache_miss_ready_o);
        end
        tick();
        clear_inputs();
    endtask

`ifdef NC_L2_TIMEOUT_EN
    task automatic test_timeout();
        go_to_wait(40'h00_0000_7000);
        l2_rsp_data_i = 512'hF00D;
        for (int k = 1; k <= 8; k++) begin
            total++; if (nc_grant_valid_o !== (k == 8) || nc_err_o !== (k == 8)) begin
                bad++; $display("FAIL to_cycle%0d got g=%0b e=%0b exp=%0b", k, nc_grant_valid_o, nc_err_o, (k == 8));
            end
            if (k == 8) begin
                total++; if (rsp_data_o !== '0) begin bad++; $display("FAIL to_data got=%h exp=0", rsp_data_o); end
            end
            tick();
        end
        clear_inputs();
        settle();
        total++; if (nc_state_o !== 2'd0) begin bad++; $display("FAIL to_idle got=%0d exp=0", nc_state_o); end
        nc_req_valid_i = 1'b1;
        nc_req_addr_i  = 40'h00_0000_8000;
        tick();
        clear_inputs();
        settle();
        total++; if (l2_req_valid_o !== 1'b0) begin bad++; $display("FAIL to_stale_block got=%0b exp=0", l2_req_valid_o); end
        l2_rsp_valid_i = 1'b1;
        l2_rsp_nc_i    = 1'b1;
        l2_rsp_data_i  = 512'h99;
        settle();
        total++; if (nc_grant_valid_o !== 1'b0) begin bad++; $display("FAIL to_late_drop got=%0b exp=0", nc_grant_valid_o); end
        tick();
        clear_inputs();
        settle();
        total++; if (l2_req_valid_o !== 1'b1 || l2_req_nc_o !== 1'b1 || l2_req_addr_o !== 40'h00_0000_8000) begin
            bad++; $display("FAIL to_reissue got v=%0b nc=%0b addr=%h exp=1/1/0000008000", l2_req_valid_o, l2_req_nc_o, l2_req_addr_o);
        end
        l2_req_ready_i = 1'b1;
        tick();
        clear_inputs();
        l2_rsp_valid_i = 1'b1;
        l2_rsp_nc_i    = 1'b1;
        l2_rsp_data_i  = 512'h77;
        settle();
        total++; if (nc_grant_valid_o !== 1'b1 || nc_err_o !== 1'b0 || rsp_data_o !== 512'h77) begin
            bad++; $display("FAIL to_next_ok got g=%0b e=%0b d=%h exp=1/0/77", nc_grant_valid_o, nc_err_o, rsp_data_o);
        end
        tick();
        clear_inputs();
    endtask
`else
    task automatic test_no_timeout();
        go_to_wait(40'h00_0000_7000);
        for (int k = 1; k <= 20; k++) begin
            total++; if (nc_grant_valid_o !== 1'b0 || nc_err_o !== 1'b0) begin
                bad++; $display("FAIL nto_cycle%0d got g=%0b e=%0b exp=0/0", k, nc_grant_valid_o, nc_err_o);
            end
            tick();
        end
        settle();
        total++; if (nc_state_o !== 2'd2) begin bad++; $display("FAIL nto_still_wait got=%0d exp=2", nc_state_o); end
        l2_rsp_valid_i = 1'b1;
        l2_rsp_nc_i    = 1'b1;
        l2_rsp_data_i  = 512'h42;
        settle();
        total++; if (nc_grant_valid_o !== 1'b1 || rsp_data_o !== 512'h42) begin bad++; $display("FAIL nto_grant got=%0b d=%h exp=1/42", nc_grant_valid_o, rsp_data_o); end
        tick();
        clear_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_nc_basic();
        test_arbitration();
        test_ignore_second();
        test_miss_rsp_in_wait();
        test_drop_and_overlap();
        test_reset_mid();
`ifdef NC_L2_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nc_l2_req_adapter.md
NC_L2_REQ_ADAPTER -- requirements
Module: nc_l2_req_adapter

Interface
REQ-001 SHALL have parameter L2_DATA_WIDTH, default 512: L2 response data width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: NC wait limit, used only under NC_L2_TIMEOUT_EN.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; rstn_i  in  1  reset.
REQ-004 nc_req_valid_i  in  1  single-cycle NC fetch request pulse.
REQ-005 nc_req_addr_i  in  40  NC physical address, bits [2:0] zero.
REQ-006 icache_miss_valid_i  in  1  cacheable line-miss request, held until accepted.
REQ-007 icache_miss_addr_i  in  40  miss line address.
REQ-008 icache_miss_ready_o  out  1  miss accepted this cycle.
REQ-009 l2_req_valid_o  out  1  L2 request valid.
REQ-010 l2_req_ready_i  in  1  L2 accepts request.
REQ-011 l2_req_addr_o  out  40  request address.
REQ-012 l2_req_nc_o  out  1  request is non-cacheable; also the transaction tag.
REQ-013 l2_rsp_valid_i  in  1  L2 response valid, single cycle.
REQ-014 l2_rsp_nc_i  in  1  response tag.
REQ-015 l2_rsp_data_i  in  L2_DATA_WIDTH  response data.
REQ-016 nc_grant_valid_o  out  1  NC response to the NC buffer.
REQ-017 icache_rsp_valid_o  out  1  cacheable response to the icache.
REQ-018 rsp_data_o  out  L2_DATA_WIDTH  response data, shared by both grants.
REQ-019 nc_err_o  out  1  NC grant is a timeout completion.

Function
REQ-020 The NC path SHALL use an FSM with states NC_IDLE, NC_PEND and NC_WAIT.
REQ-021 NC_IDLE: nc_req_valid_i SHALL latch the address and enter NC_PEND on the next cycle.
REQ-022 NC_PEND: l2_req_valid_o=1 with l2_req_nc_o=1 and the latched address; on l2_req_ready_i SHALL enter NC_WAIT.
REQ-023 NC_WAIT: l2_rsp_valid_i with l2_rsp_nc_i=1 SHALL return to NC_IDLE.
REQ-024 nc_req_valid_i outside NC_IDLE SHALL be ignored and SHALL NOT modify the latched address.
REQ-025 Arbitration: NC_PEND SHALL have priority over a miss; a miss SHALL be forwarded (l2_req_nc_o=0) only when the NC FSM is not in NC_PEND.
REQ-026 icache_miss_ready_o SHALL equal l2_req_ready_i when the miss is forwarded, and 0 otherwise.
REQ-027 Every request output SHALL be combinational from registered state and the miss inputs; request latency from an NC pulse to l2_req_valid_o SHALL be 1 cycle.
REQ-028 Response routing SHALL be combinational, same cycle:
- nc_grant_valid_o = l2_rsp_valid_i & l2_rsp_nc_i & NC_WAIT.
- icache_rsp_valid_o = l2_rsp_valid_i & ~l2_rsp_nc_i.
- rsp_data_o = l2_rsp_data_i.
REQ-029 An NC-tagged response outside NC_WAIT SHALL be dropped (no grant).
REQ-030 A response and a new NC pulse in the same cycle, both in NC_IDLE, SHALL latch the pulse.
REQ-031 An NC pulse arriving in the cycle NC_WAIT completes SHALL be ignored; upstream busy covers that cycle.

Reset
REQ-032 On reset the SHALL hold: NC_IDLE, latched address 0, timeout counter 0, stale flag 0.
REQ-033 During and after reset, until new activity, every output SHALL be 0.
REQ-034 Reset mid-transaction SHALL abandon it; a late response SHALL then be dropped per REQ-029.

Configuration
REQ-035 NC_L2_TIMEOUT_EN defined:
- A counter SHALL run in NC_WAIT.
- At TIMEOUT_CYCLES it SHALL assert nc_grant_valid_o and nc_err_o for one cycle, drive rsp_data_o to 0 and return to NC_IDLE.
- It SHALL set a stale flag that drops the next NC-tagged response and then clears.
- While the stale flag is set, NC_PEND SHALL NOT issue.
REQ-036 NC_L2_TIMEOUT_EN undefined: there SHALL be no counter or stale logic, nc_err_o SHALL be tied to 0, and NC_WAIT SHALL be unbounded.

Structure
REQ-037 The FSM state enum and the NC_TAG/IC_TAG constants SHALL live in sargantana_icache_pkg.
REQ-038 The timeout counter SHALL be a sub-module, nc_timeout_cnt, instantiated only under the macro.

Verification
REQ-039 NC pulse, addr 0x00_0001_0008, ready=1 -> l2_req_valid_o one cycle later, addr 0x00_0001_0008, nc=1; a response of 0xDEAD one cycle later -> nc_grant_valid_o=1, rsp_data_o=0xDEAD.
REQ-040 NC_PEND with a miss at 0x8000_0040 and ready=1 -> NC issued first, icache_miss_ready_o=0; the miss is accepted in the following cycle.
REQ-041 Two NC pulses 2 cycles apart, ready=0 -> second ignored; the issued address equals the first.
REQ-042 Miss response (nc=0) during NC_WAIT -> icache_rsp_valid_o=1, nc_grant_valid_o=0, state unchanged.
REQ-043 With the macro and TIMEOUT_CYCLES=8, no response -> grant plus nc_err_o at wait cycle 8; a late NC response is dropped; the next request proceeds normally.
REQ-044 Reset asserted in NC_WAIT, then an NC response -> no grant, all outputs 0.
